// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase NCO: angle constants in
// degrees*2^16, the controller state type and a modulo-360 angle adder.
package cordic_pkg;

   localparam int ANGLE_WIDTH = 25;

   localparam logic [ANGLE_WIDTH-1:0] DEG45  = 25'd2949120;
   localparam logic [ANGLE_WIDTH-1:0] DEG90  = 25'd5898240;
   localparam logic [ANGLE_WIDTH-1:0] DEG135 = 25'd8847360;
   localparam logic [ANGLE_WIDTH-1:0] DEG180 = 25'd11796480;
   localparam logic [ANGLE_WIDTH-1:0] DEG225 = 25'd14745600;
   localparam logic [ANGLE_WIDTH-1:0] DEG270 = 25'd17694720;
   localparam logic [ANGLE_WIDTH-1:0] DEG315 = 25'd20643840;
   localparam logic [ANGLE_WIDTH-1:0] DEG360 = 25'd23592960;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } nco_state_t;

   // Both operands are below 360 degrees, so one conditional subtract
   // brings the sum back into [0, 360).
   function automatic logic [ANGLE_WIDTH-1:0] wrap_add(input logic [ANGLE_WIDTH-1:0] a,
                                                       input logic [ANGLE_WIDTH-1:0] b);
      logic [ANGLE_WIDTH:0] sum;
      logic [ANGLE_WIDTH:0] res;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, DEG360}) begin
         res = sum - {1'b0, DEG360};
      end else begin
         res = sum;
      end
      return res[ANGLE_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/cordic_quadrant_map.sv
// Combinational angle -> {quadrant, residual} map. The residual is the
// distance to the nearest axis, always in [-45, +45) degrees, so the
// downstream CORDIC only has to rotate through a small angle.
module cordic_quadrant_map
   import cordic_pkg::*;
(
   input  logic [ANGLE_WIDTH-1:0] angle,
   output logic [1:0]             quad,
   output logic [29:0]            resid
);

   logic [29:0] a_ext;

   assign a_ext = {5'd0, angle};

   // Pick the nearest axis and subtract it from the angle.
   always_comb begin
      quad  = 2'd0;
      resid = a_ext;
      if (angle < DEG45) begin
         quad  = 2'd0;
         resid = a_ext;
      end else if (angle < DEG135) begin
         quad  = 2'd1;
         resid = a_ext - {5'd0, DEG90};
      end else if (angle < DEG225) begin
         quad  = 2'd2;
         resid = a_ext - {5'd0, DEG180};
      end else if (angle < DEG315) begin
         quad  = 2'd3;
         resid = a_ext - {5'd0, DEG270};
      end else begin
         quad  = 2'd0;
         resid = a_ext - {5'd0, DEG360};
      end
   end

endmodule

// File: rtl/cordic_phase_nco.sv
// Phase NCO feeding a CORDIC_COS_SIN stage. Issues one angle per cycle
// (stallable by hold, abortable by stop), maps it to quadrant+residual and
// presents it one cycle later with the start vector {amp, 0}.
// Optional build macro CORDIC_NCO_CHIRP_EN adds a step_inc input that ramps
// the per-sample step after every issue (linear chirp).
module cordic_phase_nco
   import cordic_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int PHASE_WIDTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   hold,
   input  logic [ANGLE_WIDTH-1:0] init_phase,
   input  logic [ANGLE_WIDTH-1:0] step,
`ifdef CORDIC_NCO_CHIRP_EN
   input  logic [ANGLE_WIDTH-1:0] step_inc,
`endif
   input  logic [CNT_WIDTH-1:0]   count,
   input  logic [DATA_WIDTH-1:0]  amp,
   output logic                   en,
   output logic [DATA_WIDTH-1:0]  x0,
   output logic [DATA_WIDTH-1:0]  y0,
   output logic [PHASE_WIDTH-1:0] phase,
   output logic                   busy,
   output logic                   done
);

   nco_state_t             state_r, state_nx;
   logic [ANGLE_WIDTH-1:0] acc_r, step_r, angle_r;
   logic [CNT_WIDTH-1:0]   count_r, cnt_r;
   logic [DATA_WIDTH-1:0]  amp_r;
   logic                   vld_r;
   logic                   active_s, issue_s, last_s, kill_s;
   logic [1:0]             quad_s;
   logic [29:0]            resid_s;
`ifdef CORDIC_NCO_CHIRP_EN
   logic [ANGLE_WIDTH-1:0] step_inc_r;
`endif

   // Hold is acted on in the cycle it is seen, so an N-cycle hold removes
   // exactly N issue slots; stop overrides both hold and issue.
   assign active_s = (state_r == ST_RUN) || (state_r == ST_HOLD);
   assign kill_s   = active_s && stop;
   assign issue_s  = active_s && !stop && !hold;
   assign last_s   = (count_r != {CNT_WIDTH{1'b0}}) && (cnt_r == count_r - CNT_WIDTH'(1));

   // Next-state logic for the burst controller.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx = ST_RUN;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RUN, ST_HOLD: begin
            if (stop) begin
               state_nx = ST_IDLE;
            end else if (issue_s && last_s) begin
               state_nx = ST_DONE;
            end else if (hold) begin
               state_nx = ST_HOLD;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Burst parameter latch, phase accumulator, sample counter and issue stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r   <= {ANGLE_WIDTH{1'b0}};
         step_r  <= {ANGLE_WIDTH{1'b0}};
         count_r <= {CNT_WIDTH{1'b0}};
         cnt_r   <= {CNT_WIDTH{1'b0}};
         amp_r   <= {DATA_WIDTH{1'b0}};
         angle_r <= {ANGLE_WIDTH{1'b0}};
         vld_r   <= 1'b0;
`ifdef CORDIC_NCO_CHIRP_EN
         step_inc_r <= {ANGLE_WIDTH{1'b0}};
`endif
      end else begin
         if ((state_r == ST_IDLE) && start) begin
            acc_r   <= init_phase;
            step_r  <= step;
            count_r <= count;
            amp_r   <= amp;
            cnt_r   <= {CNT_WIDTH{1'b0}};
`ifdef CORDIC_NCO_CHIRP_EN
            step_inc_r <= step_inc;
`endif
         end else if (issue_s) begin
            acc_r <= wrap_add(acc_r, step_r);
            cnt_r <= cnt_r + CNT_WIDTH'(1);
`ifdef CORDIC_NCO_CHIRP_EN
            step_r <= wrap_add(step_r, step_inc_r);
`endif
         end
         angle_r <= issue_s ? acc_r : {ANGLE_WIDTH{1'b0}};
         vld_r   <= issue_s;
      end
   end

   cordic_quadrant_map u_map (
      .angle (angle_r),
      .quad  (quad_s),
      .resid (resid_s)
   );

   // Registered outputs; a sample still in flight when stop lands is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en    <= 1'b0;
         x0    <= {DATA_WIDTH{1'b0}};
         y0    <= {DATA_WIDTH{1'b0}};
         phase <= {PHASE_WIDTH{1'b0}};
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (vld_r && !kill_s) begin
            en    <= 1'b1;
            x0    <= amp_r;
            y0    <= {DATA_WIDTH{1'b0}};
            phase <= PHASE_WIDTH'({quad_s, resid_s});
         end else begin
            en    <= 1'b0;
            x0    <= {DATA_WIDTH{1'b0}};
            y0    <= {DATA_WIDTH{1'b0}};
            phase <= {PHASE_WIDTH{1'b0}};
         end
         busy <= (state_nx == ST_RUN) || (state_nx == ST_HOLD);
         done <= (state_r == ST_DONE);
      end
   end

endmodule

// File: tb/tb_cordic_phase_nco.sv
// Self-checking bench for cordic_phase_nco: table of bursts (fixed cases
// plus random ones scored by a closed-form angle model), then hand-written
// stop, reset and optional chirp sequences.
module tb_cordic_phase_nco;

   localparam longint D    = 65536;
   localparam longint FULL = 360 * 65536;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, stop = 1'b0, hold = 1'b0;
   logic [24:0] init_phase = 25'd0, step = 25'd0;
`ifdef CORDIC_NCO_CHIRP_EN
   logic [24:0] step_inc = 25'd0;
`endif
   logic [15:0] count = 16'd0, amp = 16'd0;
   logic        en, busy, done;
   logic [15:0] x0, y0;
   logic [31:0] phase;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct packed {
      logic [24:0]      init;
      logic [24:0]      step;
      logic [24:0]      inc;
      logic [15:0]      cnt;
      logic [15:0]      amp;
      logic [3:0]       hold_len;
      logic [7:0][31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] ph;
      logic [15:0] x;
      logic [15:0] y;
      logic        d;
      int          c;
   } smp_t;

   smp_t mon_q[$];
   int   done_cnt = 0;

   cordic_phase_nco dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
      .init_phase(init_phase), .step(step),
`ifdef CORDIC_NCO_CHIRP_EN
      .step_inc(step_inc),
`endif
      .count(count), .amp(amp), .en(en), .x0(x0), .y0(y0),
      .phase(phase), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every sample strobe and every done pulse on the falling edge.
   always @(negedge clk) begin
      if (en) mon_q.push_back('{phase, x0, y0, done, cyc});
      if (done) done_cnt = done_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks = checks + 1;
      if (act !== expv) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Angle of the k-th sample: init + k*step + inc*k(k-1)/2, modulo 360.
   function automatic longint ref_angle(input longint init, input longint stp,
                                        input longint inc, input longint k);
      return (init + k * stp + inc * ((k * (k - 1)) / 2)) % FULL;
   endfunction

   // Quadrant and residual of an angle, from the nearest-axis rule.
   function automatic logic [31:0] ref_phase(input longint a);
      logic [1:0]  q;
      longint      r;
      logic [29:0] r30;
      if (a < 45 * D)       begin q = 2'd0; r = a; end
      else if (a < 135 * D) begin q = 2'd1; r = a - 90 * D; end
      else if (a < 225 * D) begin q = 2'd2; r = a - 180 * D; end
      else if (a < 315 * D) begin q = 2'd3; r = a - 270 * D; end
      else                  begin q = 2'd0; r = a - 360 * D; end
      r30 = r[29:0];
      return {q, r30};
   endfunction

   task automatic run_burst(input vec_t v, input string tag);
      int base, dbase, start_cyc, t, nseen, n;
      bit fin, hdone;
      base  = mon_q.size();
      dbase = done_cnt;
      @(posedge clk); #1;
      init_phase = v.init; step = v.step; count = v.cnt; amp = v.amp;
`ifdef CORDIC_NCO_CHIRP_EN
      step_inc = v.inc;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start_cyc = cyc;
      start = 1'b0;
      fin = 1'b0; hdone = 1'b0; nseen = 0; t = 0;
      while (!fin && t < 300) begin
         @(negedge clk);
         t = t + 1;
         if (en) nseen = nseen + 1;
         if (done) fin = 1'b1;
         if (v.hold_len != 4'd0 && !hdone && nseen == 1) begin
            hold = 1'b1;
            repeat (int'(v.hold_len)) @(posedge clk);
            #1 hold = 1'b0;
            hdone = 1'b1;
         end
      end
      chk({tag, "_done_seen"}, 64'(fin), 64'd1);
      repeat (3) @(negedge clk);
      n = mon_q.size() - base;
      chk({tag, "_en_count"}, 64'(n), 64'(v.cnt));
      for (int k = 0; k < n && k < 8; k++) begin
         chk($sformatf("%s_phase%0d", tag, k), 64'(mon_q[base + k].ph), 64'(v.exp[k]));
         chk($sformatf("%s_x0_%0d", tag, k), 64'(mon_q[base + k].x), 64'(v.amp));
         chk($sformatf("%s_y0_%0d", tag, k), 64'(mon_q[base + k].y), 64'd0);
      end
      if (n > 0) begin
         chk({tag, "_latency"}, 64'(mon_q[base].c - start_cyc), 64'd2);
         chk({tag, "_span"}, 64'(mon_q[base + n - 1].c - mon_q[base].c),
             64'(int'(v.cnt) - 1 + int'(v.hold_len)));
         chk({tag, "_done_with_last"}, 64'(mon_q[base + n - 1].d), 64'd1);
      end
      if (v.hold_len != 4'd0 && n >= 3) begin
         chk({tag, "_hold_gap"}, 64'(mon_q[base + 2].c - mon_q[base + 1].c),
             64'(int'(v.hold_len) + 1));
      end
      chk({tag, "_done_pulses"}, 64'(done_cnt - dbase), 64'd1);
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   logic [31:0] req032 [8] = '{32'h00000000, 32'h7FD30000, 32'h40000000, 32'hBFD30000,
                               32'h80000000, 32'hFFD30000, 32'hC0000000, 32'h3FD30000};

   vec_t vecs [8];

   initial begin
      int base, dbase, nseen, t;
      vec_t v;

      // Table: fixed cases first, then random bursts scored by the model.
      vecs[0] = '0;
      vecs[0].init = 25'd0; vecs[0].step = 25'd2949120; vecs[0].cnt = 16'd8;
      vecs[0].amp  = 16'd39797;
      for (int k = 0; k < 8; k++) vecs[0].exp[k] = req032[k];
      vecs[1] = '0;
      vecs[1].init = 25'd22937600; vecs[1].step = 25'd1310720; vecs[1].cnt = 16'd2;
      vecs[1].amp  = 16'd39797;
      vecs[1].exp[0] = 32'h3FF60000;
      vecs[1].exp[1] = 32'h000A0000;
      vecs[2] = vecs[0];
      vecs[2].hold_len = 4'd3;
      for (int i = 3; i < 8; i++) begin
         vecs[i] = '0;
         vecs[i].init = 25'($urandom_range(0, 23592959));
         vecs[i].step = 25'($urandom_range(0, 23592959));
         vecs[i].cnt  = 16'($urandom_range(1, 8));
         vecs[i].amp  = 16'($urandom);
         vecs[i].hold_len = (vecs[i].cnt >= 16'd3) ? 4'($urandom_range(0, 3)) : 4'd0;
         for (int k = 0; k < 8; k++)
            vecs[i].exp[k] = ref_phase(ref_angle(longint'(vecs[i].init),
                                                 longint'(vecs[i].step), 0, k));
      end

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset_en", 64'(en), 64'd0);
      chk("reset_phase", 64'(phase), 64'd0);
      chk("reset_x0", 64'(x0), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

      // Continuous burst: start while busy is ignored, stop after 5 samples.
      base = mon_q.size(); dbase = done_cnt;
      v = '0;
      v.init = 25'($urandom_range(0, 23592959));
      v.step = 25'($urandom_range(0, 23592959));
      @(posedge clk); #1;
      init_phase = v.init; step = v.step; count = 16'd0; amp = 16'd1234; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nseen = 0; t = 0;
      while (nseen < 5 && t < 100) begin
         @(negedge clk);
         t = t + 1;
         if (en) nseen = nseen + 1;
         if (nseen == 2 && t < 100) begin
            init_phase = 25'd1000; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            t = t + 1;
            if (en) nseen = nseen + 1;
         end
      end
      chk("stop_reached5", 64'(nseen), 64'd5);
      stop = 1'b1; start = 1'b1; hold = 1'b1;
      @(posedge clk); #1 stop = 1'b0; start = 1'b0; hold = 1'b0;
      repeat (10) @(negedge clk);
      chk("stop_en_total", 64'(mon_q.size() - base), 64'd5);
      chk("stop_no_done", 64'(done_cnt - dbase), 64'd0);
      chk("stop_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 5 && base + k < mon_q.size(); k++)
         chk($sformatf("stop_phase%0d", k), 64'(mon_q[base + k].ph),
             64'(ref_phase(ref_angle(longint'(v.init), longint'(v.step), 0, k))));

      // Reset mid-burst, then a fresh burst from init_phase.
      base = mon_q.size();
      @(posedge clk); #1;
      init_phase = vecs[0].init; step = vecs[0].step; count = 16'd8; amp = vecs[0].amp;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      nseen = 0; t = 0;
      while (nseen < 3 && t < 100) begin
         @(negedge clk);
         t = t + 1;
         if (en) nseen = nseen + 1;
      end
      #2 rst = 1'b0;
      #1;
      chk("rst_en", 64'(en), 64'd0);
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_x0", 64'(x0), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk) rst = 1'b1;
      base = mon_q.size();
      repeat (4) @(negedge clk);
      chk("rst_no_inflight", 64'(mon_q.size() - base), 64'd0);
      run_burst(vecs[0], "post_rst");

`ifdef CORDIC_NCO_CHIRP_EN
      v = '0;
      v.init = 25'd0; v.step = 25'd655360; v.inc = 25'd655360; v.cnt = 16'd4;
      v.amp = 16'd39797;
      v.exp[0] = 32'h00000000; v.exp[1] = 32'h000A0000;
      v.exp[2] = 32'h001E0000; v.exp[3] = 32'h7FE20000;
      run_burst(v, "chirp");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
